// File: rtl/uart_apb_tx_feeder.sv
// Byte FIFO that drains into a UART transmit-data register over APB,
// one write per TXRDY indication, with a fixed idle holdoff after each write.
module uart_apb_tx_feeder #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter logic [4:0]  TXDATA_ADDR    = 5'h00,
  parameter int unsigned HOLDOFF_CYCLES = 2
) (
  input  logic                          PCLK,
  input  logic                          PRESETN,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          TXRDY,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [4:0]                    PADDR,
  output logic [7:0]                    PWDATA,
  input  logic                          PREADY,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [3:0]    HOLD_INIT = 4'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t          state_q;
  logic [3:0]      hold_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            push, pop;

  // Fullness comes from the registered count only, so a same-edge pop never frees a slot early.
  assign in_ready   = (count_q != FULL_CNT);
  assign push       = in_valid && in_ready;
  assign pop        = (state_q == ACCESS) && PREADY;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= IDLE;
      hold_q  <= '0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((count_q != '0) && TXRDY) begin
            state_q <= SETUP;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b1;
            PADDR   <= TXDATA_ADDR;
            PWDATA  <= mem_q[rd_ptr_q];
          end
        end
        SETUP: begin
          state_q <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (PREADY) begin
            state_q <= HOLDOFF;
            hold_q  <= HOLD_INIT;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
          end
        end
        HOLDOFF: begin
          // Leave on the edge where the counter reaches zero; TXRDY is not looked at here.
          hold_q <= (hold_q == '0) ? '0 : hold_q - 4'd1;
          if (hold_q <= 4'd1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_tx_feeder.sv
// Directed bench for uart_apb_tx_feeder: APB write monitor plus hand-computed
// expectations for push/drain, full-FIFO, wait-state and reset scenarios.
module tb_uart_apb_tx_feeder;

  logic       PCLK = 1'b0;
  logic       PRESETN;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       TXRDY;
  logic       PSEL, PENABLE, PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA;
  logic       PREADY;
  logic [3:0] fifo_count;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [7:0] wr_q[$];
  int         setup_cyc[$];
  logic [7:0] setup_data;

  always #5 PCLK = ~PCLK;

  uart_apb_tx_feeder #(
    .FIFO_DEPTH(8),
    .TXDATA_ADDR(5'h00),
    .HOLDOFF_CYCLES(2)
  ) dut (
    .PCLK(PCLK),
    .PRESETN(PRESETN),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .TXRDY(TXRDY),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PADDR(PADDR),
    .PWDATA(PWDATA),
    .PREADY(PREADY),
    .fifo_count(fifo_count),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic wait_writes(input int n, input string tag);
    int budget = 0;
    while (wr_q.size() < n && budget < 200) begin
      step();
      budget++;
    end
    chk(tag, 32'(wr_q.size()), 32'(n));
  endtask

  task automatic wait_idle(input string tag);
    int budget = 0;
    while (busy && budget < 200) begin
      step();
      budget++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  // Mid-cycle monitor: one line per completed APB write.
  always begin
    @(negedge PCLK);
    #1;
    cyc++;
    if (PSEL && !PENABLE) begin
      setup_cyc.push_back(cyc);
      setup_data = PWDATA;
    end
    if (PSEL && PENABLE) begin
      chk("acc_pwdata_stable", 32'(PWDATA), 32'(setup_data));
      chk("acc_paddr", 32'(PADDR), 32'h00);
      chk("acc_pwrite", 32'(PWRITE), 32'd1);
      if (PREADY) begin
        wr_q.push_back(PWDATA);
        $display("apb write: cycle %0d data %02h", cyc, PWDATA);
      end
    end
  end

  initial begin
    PRESETN  = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    TXRDY    = 1'b1;
    PREADY   = 1'b1;

    // Reset values.
    @(negedge PCLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwdata", 32'(PWDATA), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single byte: push on the first edge after reset release.
    @(negedge PCLK);
    PRESETN  = 1'b1;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("a5_count_after_push", 32'(fifo_count), 32'd1);
    chk("a5_psel_idle", 32'(PSEL), 32'd0);
    step();
    chk("a5_setup_psel", 32'(PSEL), 32'd1);
    chk("a5_setup_penable", 32'(PENABLE), 32'd0);
    chk("a5_setup_pwrite", 32'(PWRITE), 32'd1);
    chk("a5_setup_paddr", 32'(PADDR), 32'h00);
    chk("a5_setup_pwdata", 32'(PWDATA), 32'hA5);
    step();
    chk("a5_access_psel", 32'(PSEL), 32'd1);
    chk("a5_access_penable", 32'(PENABLE), 32'd1);
    step();
    chk("a5_hold_psel", 32'(PSEL), 32'd0);
    chk("a5_hold_pwrite", 32'(PWRITE), 32'd0);
    chk("a5_hold_pwdata_kept", 32'(PWDATA), 32'hA5);
    chk("a5_count_popped", 32'(fifo_count), 32'd0);
    chk("a5_hold_busy1", 32'(busy), 32'd1);
    step();
    chk("a5_hold_busy2", 32'(busy), 32'd1);
    step();
    chk("a5_idle_busy", 32'(busy), 32'd0);
    chk("a5_write_seen", 32'(wr_q.size()), 32'd1);

    // Fill to full with TXRDY low, refuse the ninth, then drain in order.
    wr_q.delete();
    setup_cyc.delete();
    TXRDY = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data  = 8'(i + 1);
      in_valid = 1'b1;
      step();
    end
    chk("full_count", 32'(fifo_count), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_data = 8'h09;
    step();
    in_valid = 1'b0;
    chk("full_ninth_refused", 32'(fifo_count), 32'd8);
    chk("full_no_write_txrdy_low", 32'(wr_q.size()), 32'd0);
    TXRDY = 1'b1;
    wait_writes(8, "drain_writes");
    for (int i = 0; i < 8 && i < wr_q.size(); i++)
      chk($sformatf("drain_order_%0d", i), 32'(wr_q[i]), 32'(i + 1));
    for (int i = 1; i < 8 && i < setup_cyc.size(); i++)
      chk($sformatf("drain_spacing_%0d", i), 32'(setup_cyc[i] - setup_cyc[i-1]), 32'd5);
    wait_idle("drain_idle");

    // Wait states: PREADY low for three ACCESS cycles.
    wr_q.delete();
    PREADY   = 1'b0;
    in_data  = 8'h3C;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("ws_setup", 32'(PSEL && !PENABLE), 32'd1);
    step();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ws_psel_%0d", k), 32'(PSEL), 32'd1);
      chk($sformatf("ws_penable_%0d", k), 32'(PENABLE), 32'd1);
      chk($sformatf("ws_pwdata_%0d", k), 32'(PWDATA), 32'h3C);
      chk($sformatf("ws_count_%0d", k), 32'(fifo_count), 32'd1);
      if (k == 3) PREADY = 1'b1;
      step();
    end
    chk("ws_released", 32'(PSEL), 32'd0);
    chk("ws_single_pop", 32'(fifo_count), 32'd0);
    chk("ws_one_write", 32'(wr_q.size()), 32'd1);
    wait_idle("ws_idle");

    // Full FIFO: push refused on the pop edge, accepted on the next.
    wr_q.delete();
    TXRDY = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data  = 8'h11 + 8'(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    TXRDY = 1'b1;
    step();
    step();
    chk("fp_in_access", 32'(PSEL && PENABLE), 32'd1);
    in_data  = 8'h19;
    in_valid = 1'b1;
    chk("fp_count_8", 32'(fifo_count), 32'd8);
    chk("fp_not_ready", 32'(in_ready), 32'd0);
    step();
    chk("fp_count_7", 32'(fifo_count), 32'd7);
    chk("fp_ready_again", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("fp_count_8_again", 32'(fifo_count), 32'd8);
    wait_writes(9, "fp_writes");
    for (int i = 0; i < 9 && i < wr_q.size(); i++)
      chk($sformatf("fp_order_%0d", i), 32'(wr_q[i]), 32'(8'h11 + 8'(i)));
    wait_idle("fp_idle");

    // Asynchronous reset in the middle of a stalled ACCESS.
    TXRDY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data  = 8'hC0 + 8'(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    TXRDY  = 1'b1;
    PREADY = 1'b0;
    step();
    step();
    step();
    chk("ar_in_access", 32'(PSEL && PENABLE), 32'd1);
    chk("ar_count_5", 32'(fifo_count), 32'd5);
    #2;
    PRESETN = 1'b0;
    #1;
    chk("ar_psel_dropped", 32'(PSEL), 32'd0);
    chk("ar_penable_dropped", 32'(PENABLE), 32'd0);
    chk("ar_count_cleared", 32'(fifo_count), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    @(negedge PCLK);
    PRESETN = 1'b1;
    PREADY  = 1'b1;
    wr_q.delete();
    setup_cyc.delete();
    repeat (10) step();
    chk("ar_no_setup", 32'(setup_cyc.size()), 32'd0);
    chk("ar_no_write", 32'(wr_q.size()), 32'd0);
    in_data  = 8'h5A;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_writes(1, "ar_new_write");
    if (wr_q.size() > 0) chk("ar_new_data", 32'(wr_q[0]), 32'h5A);
    wait_idle("ar_idle");

    // Pattern bytes back to back.
    wr_q.delete();
    for (int i = 0; i < 3; i++) begin
      in_data  = (i == 0) ? 8'h55 : (i == 1) ? 8'h00 : 8'hFF;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    wait_writes(3, "pat_writes");
    if (wr_q.size() > 2) begin
      chk("pat_55", 32'(wr_q[0]), 32'h55);
      chk("pat_00", 32'(wr_q[1]), 32'h00);
      chk("pat_ff", 32'(wr_q[2]), 32'hFF);
    end
    wait_idle("pat_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
